// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract
// step per clock, sign fix-up in a final cycle, plus direct HI/LO writes.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             annul_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  // upper_q: partial product high half / partial remainder.
  // lower_q: multiplier being shifted out / dividend shifting into quotient.
  logic [WIDTH-1:0] upper_q, upper_d;
  logic [WIDTH-1:0] lower_q, lower_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             sgn_a_q, sgn_a_d;
  logic             sgn_b_q, sgn_b_d;

  logic             idle_like;
  logic             accept;
  logic             in_sgn;
  logic             in_div;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;

  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Input decode and operand magnitudes for the accept cycle.
  always_comb begin
    idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    accept    = start_i & idle_like & ~annul_i;
    in_sgn    = ~op_i[2] & ~op_i[0];
    in_div    = op_i[1];
    mag_a     = (in_sgn && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
    mag_b     = (in_sgn && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;
  end

  // One iteration step for each operation.
  always_comb begin
    mul_sum  = {1'b0, upper_q} + (lower_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {upper_q, lower_q[WIDTH-1]};
    // rem_sh < 2*divisor, so bit WIDTH of the difference is a valid sign bit.
    rem_diff = rem_sh - {1'b0, opnd_q};
    rem_ge   = ~rem_diff[WIDTH];
  end

  // Sign fix-up applied in FIX; the sign flags are zero for unsigned ops.
  always_comb begin
    prod_raw = {upper_q, lower_q};
    prod_fix = (sgn_a_q ^ sgn_b_q) ? -prod_raw : prod_raw;
    quot_fix = (sgn_a_q ^ sgn_b_q) ? -lower_q : lower_q;
    rem_fix  = sgn_a_q ? -upper_q : upper_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    upper_d  = upper_q;
    lower_d  = lower_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    sgn_a_d  = sgn_a_q;
    sgn_b_d  = sgn_b_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (op_i == OP_MTHI) begin
            hi_d = src_a_i;
          end else if (op_i == OP_MTLO) begin
            lo_d = src_a_i;
          end else if (!op_i[2]) begin
            if (in_div && (src_b_i == '0)) begin
              lo_d    = '1;
              hi_d    = src_a_i;
              state_d = S_DONE;
            end else begin
              state_d  = S_RUN;
              cnt_d    = '0;
              upper_d  = '0;
              lower_d  = in_div ? mag_a : mag_b;
              opnd_d   = in_div ? mag_b : mag_a;
              is_div_d = in_div;
              sgn_a_d  = in_sgn & src_a_i[WIDTH-1];
              sgn_b_d  = in_sgn & src_b_i[WIDTH-1];
            end
          end
        end
      end

      S_RUN: begin
        if (annul_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (is_div_q) begin
            upper_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lower_d = {lower_q[WIDTH-2:0], rem_ge};
          end else begin
            upper_d = mul_sum[WIDTH:1];
            lower_d = {mul_sum[0], lower_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!annul_i) begin
          state_d = S_DONE;
          if (is_div_q) begin
            lo_d = quot_fix;
            hi_d = rem_fix;
          end else begin
            lo_d = prod_fix[WIDTH-1:0];
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      upper_q  <= '0;
      lower_q  <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sgn_a_q  <= 1'b0;
      sgn_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      upper_q  <= upper_d;
      lower_q  <= lower_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      sgn_a_q  <= sgn_a_d;
      sgn_b_q  <= sgn_b_d;
    end
  end

  // Handshake: a mul/div request with start_i=1 is taken on the clock edge of
  // a cycle where stall_o's request term is 1 (IDLE/DONE, annul_i=0); the
  // requester must hold the stage while stall_o=1. Status outputs read 0 in reset.
  always_comb begin
    busy_o  = ~rst & ((state_q == S_RUN) || (state_q == S_FIX));
    done_o  = ~rst & (state_q == S_DONE);
    stall_o = ~rst & (((state_q == S_RUN) || (state_q == S_FIX)) |
                      (start_i & ~op_i[2] & idle_like & ~annul_i));
    hi_o    = hi_q;
    lo_o    = lo_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed cases, annul/reset
// abort, ignored starts and a back-to-back random run against a reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [2:0]   op_i;
  logic [W-1:0] src_a_i;
  logic [W-1:0] src_b_i;
  logic         annul_i;
  logic         stall_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi;
  logic [W-1:0]   m_lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .op_i    (op_i),
    .src_a_i (src_a_i),
    .src_b_i (src_b_i),
    .annul_i (annul_i),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] t;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t  = '0;
    case (op)
      3'd0: t = sa * sb;
      3'd1: t = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) t = {a, 32'hFFFF_FFFF};
        else begin
          u = sa / sb;
          t = sa % sb;
          t = {t[31:0], u[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) t = {a, 32'hFFFF_FFFF};
        else t = {a % b, a / b};
      end
      default: t = '0;
    endcase
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  // Drives one request for a single cycle (caller guarantees it is accepted),
  // then scrambles the inputs so latching is exercised.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start_i = 1'b1;
    op_i    = op;
    src_a_i = a;
    src_b_i = b;
    step();
    start_i = 1'b0;
    op_i    = 3'($urandom_range(0, 7));
    src_a_i = $urandom;
    src_b_i = $urandom;
    if (op <= 3'd3) exp_q.push_back(model(op, a, b));
    if (op == 3'd4) m_hi = a;
    if (op == 3'd5) m_lo = a;
  endtask

  // Waits (bounded) for done_o; cyc is the cycle offset from the accept cycle.
  task automatic wait_done(input int c0, output int cyc, output int busy_n,
                           output int nostall_n, output bit seen);
    cyc = c0; busy_n = 0; nostall_n = 0; seen = 1'b0;
    while (!seen && cyc <= 100) begin
      if (busy_o) busy_n++;
      if (done_o) seen = 1'b1;
      else begin
        if (!stall_o) nostall_n++;
        step();
        cyc++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; annul_i = 1'b0;
    start_i = 1'b1; op_i = 3'd0; src_a_i = $urandom; src_b_i = $urandom;
    step();
    n_cmp++;
    if ({busy_o, done_o, stall_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_status: busy/done/stall=%b want 000", {busy_o, done_o, stall_o});
    end
    step();
    rst = 1'b0; start_i = 1'b0;
    #1;
    n_cmp++;
    if ({hi_o, lo_o, busy_o, done_o, stall_o} !== {64'd0, 3'b000}) begin
      n_err++;
      $display("FAIL reset_regs: hi=%h lo=%h bds=%b want 0/0/000", hi_o, lo_o,
               {busy_o, done_o, stall_o});
    end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult_timing();
    int cyc, busy_n, nostall_n;
    bit seen;
    logic [2*W-1:0] e;
    issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done(1, cyc, busy_n, nostall_n, seen);
    n_cmp++;
    if (!seen || cyc != 34) begin
      n_err++;
      $display("FAIL mult_latency: seen=%0d cyc=%0d want 34", seen, cyc);
    end
    n_cmp++;
    if (busy_n != 33 || nostall_n != 0) begin
      n_err++;
      $display("FAIL mult_busy: busy=%0d nostall=%0d want 33/0", busy_n, nostall_n);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFFA || {hi_o, lo_o} !== e) begin
      n_err++;
      $display("FAIL mult_result: got %h want %h", {hi_o, lo_o}, e);
    end
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic test_div_cases();
    logic [2:0]  ops[4]  = '{3'd2, 3'd3, 3'd2, 3'd1};
    logic [31:0] as[4]   = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs[4]   = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [63:0] spec[4] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0003,
                             64'h0000_0000_8000_0000, 64'hFFFF_FFFE_0000_0001};
    int cyc, busy_n, nostall_n;
    bit seen;
    logic [2*W-1:0] e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(1, cyc, busy_n, nostall_n, seen);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen || cyc != 34 || {hi_o, lo_o} !== spec[i] || {hi_o, lo_o} !== e) begin
        n_err++;
        $display("FAIL div_case%0d: seen=%0d cyc=%0d got %h want %h (model %h)",
                 i, seen, cyc, {hi_o, lo_o}, spec[i], e);
      end
      m_hi = e[63:32]; m_lo = e[31:0];
    end
  endtask

  task automatic test_divzero();
    int cyc, busy_n, nostall_n;
    bit seen;
    logic [2*W-1:0] e;
    issue(3'd3, 32'h1234_5678, 32'd0);
    wait_done(1, cyc, busy_n, nostall_n, seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || cyc != 1 || busy_n != 0) begin
      n_err++;
      $display("FAIL divu_zero_timing: seen=%0d cyc=%0d busy=%0d want 1/1/0", seen, cyc, busy_n);
    end
    n_cmp++;
    if ({hi_o, lo_o} !== 64'h1234_5678_FFFF_FFFF || {hi_o, lo_o} !== e) begin
      n_err++;
      $display("FAIL divu_zero_result: got %h want 12345678ffffffff", {hi_o, lo_o});
    end
    issue(3'd2, 32'h8000_0005, 32'd0);
    wait_done(1, cyc, busy_n, nostall_n, seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || cyc != 1 || busy_n != 0 || {hi_o, lo_o} !== e) begin
      n_err++;
      $display("FAIL div_zero: seen=%0d cyc=%0d got %h want %h", seen, cyc, {hi_o, lo_o}, e);
    end
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic test_mthi_annul();
    int cyc, busy_n, nostall_n;
    bit seen;
    logic [2*W-1:0] e;
    step();
    issue(3'd4, 32'h0000_1234, 32'd0);
    n_cmp++;
    if ({hi_o, done_o, busy_o} !== {32'h0000_1234, 2'b00}) begin
      n_err++;
      $display("FAIL mthi: hi=%h done=%b busy=%b want 00001234/0/0", hi_o, done_o, busy_o);
    end
    // annul in IDLE blocks both MTLO and a multiply request
    start_i = 1'b1; op_i = 3'd0; src_a_i = 32'hBEEF; annul_i = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL annul_idle_stall: stall=%b want 0", stall_o);
    end
    op_i = 3'd5;
    step();
    start_i = 1'b0; annul_i = 1'b0;
    n_cmp++;
    if ({lo_o, busy_o} !== {m_lo, 1'b0}) begin
      n_err++;
      $display("FAIL annul_idle_mtlo: lo=%h busy=%b want %h/0", lo_o, busy_o, m_lo);
    end
    issue(3'd0, 32'd5, 32'd7);
    repeat (9) step();
    annul_i = 1'b1;
    step();
    annul_i = 1'b0;
    void'(exp_q.pop_back());
    n_cmp++;
    if ({busy_o, done_o, hi_o, lo_o} !== {2'b00, 32'h0000_1234, m_lo}) begin
      n_err++;
      $display("FAIL annul_run: busy=%b done=%b hi=%h lo=%h want 0/0/00001234/%h",
               busy_o, done_o, hi_o, lo_o, m_lo);
    end
    issue(3'd0, 32'hFFFF_FFF7, 32'd1000);
    wait_done(1, cyc, busy_n, nostall_n, seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || cyc != 34 || {hi_o, lo_o} !== e) begin
      n_err++;
      $display("FAIL mult_after_annul: seen=%0d cyc=%0d got %h want %h", seen, cyc, {hi_o, lo_o}, e);
    end
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic test_ignore_start();
    int cyc, busy_n, nostall_n;
    bit seen;
    logic [2*W-1:0] e;
    step();
    issue(3'd3, $urandom, 32'($urandom_range(1, 32'h00FF_FFFF)));
    step();
    start_i = 1'b1; op_i = 3'd5; src_a_i = 32'hDEAD;
    step();
    start_i = 1'b1; op_i = 3'd0; src_a_i = 32'h77; src_b_i = 32'h99;
    step();
    start_i = 1'b0;
    wait_done(4, cyc, busy_n, nostall_n, seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || cyc != 34 || nostall_n != 0) begin
      n_err++;
      $display("FAIL ignore_start_timing: seen=%0d cyc=%0d nostall=%0d want 34/0", seen, cyc, nostall_n);
    end
    n_cmp++;
    if ({hi_o, lo_o} !== e) begin
      n_err++;
      $display("FAIL ignore_start_result: got %h want %h", {hi_o, lo_o}, e);
    end
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic test_rst_mid_div();
    int dones;
    step();
    issue(3'd2, 32'd100, 32'd7);
    repeat (4) step();
    start_i = 1'b1; op_i = 3'd4; src_a_i = 32'hAAAA;
    #1;
    n_cmp++;
    if ({stall_o, busy_o} !== 2'b11) begin
      n_err++;
      $display("FAIL run_stall: stall/busy=%b want 11", {stall_o, busy_o});
    end
    step();
    start_i = 1'b0;
    n_cmp++;
    if (hi_o !== m_hi) begin
      n_err++;
      $display("FAIL run_mthi_ignored: hi=%h want %h", hi_o, m_hi);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_q.pop_back());
    m_hi = '0; m_lo = '0;
    n_cmp++;
    if ({hi_o, lo_o, busy_o, done_o} !== {64'd0, 2'b00}) begin
      n_err++;
      $display("FAIL rst_mid_div: hi=%h lo=%h busy=%b done=%b want 0/0/0/0", hi_o, lo_o, busy_o, done_o);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o || busy_o) dones++;
      step();
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL rst_no_resume: active cycles=%0d want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, busy_n, nostall_n, want_cyc;
    bit seen;
    logic [2:0] op;
    logic [W-1:0] a, b;
    logic [2*W-1:0] e;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = '0;
      if ($urandom_range(0, 5) == 0) begin a = 32'h8000_0000; b = '1; end
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 255));
      issue(op, a, b);
      if (op >= 3'd4) begin
        n_cmp++;
        if ({hi_o, lo_o, done_o, busy_o} !== {m_hi, m_lo, 2'b00}) begin
          n_err++;
          $display("FAIL b2b_mt%0d: hi=%h lo=%h db=%b want %h/%h/00", i, hi_o, lo_o,
                   {done_o, busy_o}, m_hi, m_lo);
        end
      end else begin
        want_cyc = (op[1] && b == '0) ? 1 : 34;
        wait_done(1, cyc, busy_n, nostall_n, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || cyc != want_cyc || {hi_o, lo_o} !== e) begin
          n_err++;
          $display("FAIL b2b_op%0d_%0d: a=%h b=%h seen=%0d cyc=%0d/%0d got %h want %h",
                   op, i, a, b, seen, cyc, want_cyc, {hi_o, lo_o}, e);
        end
        m_hi = e[63:32]; m_lo = e[31:0];
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 3'd7;
    src_a_i = '0; src_b_i = '0;
    m_hi = '0; m_lo = '0;
    test_reset();
    test_mult_timing();
    test_div_cases();
    test_divzero();
    test_mthi_annul();
    test_ignore_start();
    test_rst_mid_div();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width; legal range WIDTH >= 4.
REQ-002 clk  input  1  clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  request valid this cycle.
REQ-005 op_i  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 no-op.
REQ-006 src_a_i  input  WIDTH  multiplicand/dividend; MTHI/MTLO data.
REQ-007 src_b_i  input  WIDTH  multiplier/divisor.
REQ-008 annul_i  input  1  flush; kills any operation in flight.
REQ-009 stall_o  output  1  pipeline stall request.
REQ-010 busy_o  output  1  iterative operation in progress.
REQ-011 done_o  output  1  one-cycle pulse: mul/div result committed.
REQ-012 hi_o  output  WIDTH  current HI register.
REQ-013 lo_o  output  WIDTH  current LO register.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, FIX, DONE; busy_o SHALL be 1 exactly in RUN and FIX.
REQ-015 start_i SHALL be accepted only in IDLE or DONE with annul_i=0; start_i in RUN/FIX SHALL be ignored.
REQ-016 stall_o SHALL be combinational: busy_o | (start_i & op_i in 0..3 & state in IDLE/DONE & ~annul_i).
REQ-017 On acceptance, src_a_i, src_b_i and op_i SHALL be latched; later input changes SHALL have no effect.
REQ-018 MTHI/MTLO SHALL write src_a_i into HI/LO at the accept edge, without entering RUN and without done_o.
REQ-019 MULT/DIV SHALL use operand magnitudes with sign fix-up in FIX; MULTU/DIVU SHALL use raw operands.
REQ-020 Accepted mul/div with nonzero divisor SHALL enter RUN at the accept edge E0.
REQ-021 RUN SHALL perform one iteration per edge E1..E(WIDTH): shift-add for multiply, restoring shift-subtract for divide.
REQ-022 A mod-WIDTH iteration counter SHALL move the FSM to FIX at edge E(WIDTH).
REQ-023 At edge E(WIDTH+1) (FIX) HI/LO SHALL be written and the FSM SHALL enter DONE.
REQ-024 done_o SHALL be 1 only in DONE; DONE SHALL last one cycle, then go to IDLE unless a new start is accepted.
REQ-025 Multiply result: HI = product[2W-1:W], LO = product[W-1:0], full 2W-bit product.
REQ-026 Signed multiply SHALL negate the 2W-bit product iff the operand signs differ.
REQ-027 Divide result: LO = quotient, HI = remainder.
REQ-028 Signed divide: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-029 Signed most-negative / -1 SHALL give LO = most-negative value, HI = 0, with no trap.
REQ-030 Divide by zero (DIV or DIVU) SHALL skip RUN/FIX, write LO = all ones and HI = src_a_i at E0, and enter DONE.
REQ-031 Divide by zero SHALL therefore pulse done_o in the cycle after E0.
REQ-032 annul_i in RUN/FIX SHALL return the FSM to IDLE at the next edge, leaving HI/LO unchanged and suppressing done_o.
REQ-033 annul_i in IDLE/DONE SHALL block acceptance of start_i that cycle, including MTHI/MTLO.
REQ-034 hi_o/lo_o SHALL reflect register contents only; no bypass of in-flight results.

Reset
REQ-035 rst SHALL set state IDLE, HI=0, LO=0, counter=0 and internal datapath registers to 0.
REQ-036 During rst, busy_o, done_o and stall_o SHALL be 0.
REQ-037 rst SHALL have priority over annul_i and start_i and abort any operation in flight without writing HI/LO.

Verification (WIDTH=32)
REQ-038 MULT 0xFFFFFFFE x 0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; done_o exactly 34 cycles after the accept cycle, busy_o high 33 cycles.
REQ-039 DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-040 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-041 DIVU 0x12345678 / 0 -> LO=0xFFFFFFFF, HI=0x12345678, done_o one cycle after accept, busy_o never high.
REQ-042 MTHI 0x1234 -> HI then MULT; annul_i in iteration 10 -> busy_o low next cycle, no done_o, HI=0x1234; MULT started the following cycle completes normally.
REQ-043 rst asserted mid-DIV -> HI=LO=0, IDLE next cycle; start_i during RUN ignored, stall_o remains 1 until DONE.
